score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter TICKS_PER_POINT, default 6: frame ticks per score point; legal range 1..63.
REQ-002 Parameter MILESTONE_HUNDREDS, default 1: milestone interval in hundreds of points; legal range 1..9.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 gameState  input  2  game state from the game delegate: 00 Init, 01 InGame, 10 Prepare, 11 Dead.
REQ-006 tick  input  1  one-cycle frame-tick pulse; ignored when gameState is not InGame.
REQ-007 score  output  16  current score, 4 BCD digits, [15:12] thousands.
REQ-008 hi_score  output  16  best score since reset, 4 BCD digits.
REQ-009 milestone  output  1  one-cycle pulse on reaching a milestone.
REQ-010 new_record  output  1  level; high while the current run has set hi_score.

Function
REQ-011 Prescaler: 6-bit counter, counts ticks only while gameState==InGame.
REQ-012 In InGame, tick with prescaler==TICKS_PER_POINT-1 -> prescaler to 0 and score +1 (BCD) on the same edge.
REQ-013 In InGame, any other tick -> prescaler +1; score unchanged.
REQ-014 No tick -> prescaler and score hold.
REQ-015 BCD increment: a digit at 9 goes to 0 and carries into the next digit; no digit ever holds A-F.
REQ-016 Score 9999 + 1 -> 0000 (wrap-around), with no milestone pulse.
REQ-017 Init or Prepare -> score and prescaler held at 0 every cycle.
REQ-018 Dead -> score and prescaler frozen.
REQ-019 Block registers previous gameState (prev_state) to detect transitions.
REQ-020 Entry edge into Dead is the cycle with gameState==Dead and prev_state!=Dead.
REQ-021 On that entry cycle, if score > hi_score then hi_score <= score and new_record <= 1.
REQ-022 Compare is a plain 16-bit unsigned compare of the BCD words, valid because BCD order equals numeric order.
REQ-023 Equal score does not update hi_score or set new_record.
REQ-024 new_record clears on the first cycle gameState is Prepare or Init; it holds through all of Dead.
REQ-025 milestone pulses for exactly 1 cycle, on the edge after score is incremented to a nonzero value.
REQ-026 The triggering value has [7:0]==00 and hundreds+thousands*10 divisible by MILESTONE_HUNDREDS.
REQ-027 Entry to Dead on the same cycle as a tick -> the tick is ignored; the entry-cycle compare uses the frozen score.
REQ-028 Dead->InGame without Prepare (illegal from upstream) -> score resumes from its frozen value; no assertion.
REQ-029 hi_score only ever changes at a Dead entry edge or at reset.

Reset
REQ-030 rst high -> immediately, without clk: score=0000, hi_score=0000, prescaler=0, milestone=0, new_record=0.
REQ-031 rst high also sets prev_state=Init.
REQ-032 All registers hold reset values while rst is high.
REQ-033 Reset mid-game clears hi_score too; no history survives reset.
REQ-034 First clk edge after rst falls evaluates normally; a Dead input on that edge counts as a Dead entry edge.

Verification
REQ-035 Defaults; InGame; 18 ticks at any spacing -> score 0003, one increment every 6th tick; no milestone.
REQ-036 Preload score 0099, prescaler 5; one tick -> score 0100 and milestone high for exactly 1 cycle.
REQ-037 Preload score 9999, prescaler 5; one tick -> score 0000, no milestone.
REQ-038 Sequence, hi_score starting at 0000:
- Run to 0042 -> Dead -> hi 0042, new_record 1.
- Prepare -> score 0000, new_record 0.
- Run to 0030 -> Dead -> hi stays 0042, new_record stays 0.
REQ-039 Prescaler 5, score 0007; gameState goes Dead on the same cycle as a tick -> score stays 0007; hi updated to 0007 if the old hi was lower.
REQ-040 Mid-InGame, score 0123, hi 0500; assert rst between clk edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/score_keeper_if.sv
// Score keeper bus: game-state/tick inputs and
// score, high-score and event outputs.
interface score_keeper_if;
  logic [1:0]  gameState;
  logic        tick;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        milestone;
  logic        new_record;

  modport master (
    output gameState,
    output tick,
    input  score,
    input  hi_score,
    input  milestone,
    input  new_record
  );

  modport slave (
    input  gameState,
    input  tick,
    output score,
    output hi_score,
    output milestone,
    output new_record
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: BCD score from frame ticks,
// high score latched on death, milestone pulses.
module score_keeper #(
  parameter int TICKS_PER_POINT    = 6,
  parameter int MILESTONE_HUNDREDS = 1
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_INGAME  = 2'b01,
    ST_PREPARE = 2'b10,
    ST_DEAD    = 2'b11
  } gstate_t;

  localparam logic [5:0] PS_LAST =
    6'(TICKS_PER_POINT - 1);

  gstate_t     gs;
  gstate_t     prev_state;
  logic [5:0]  prescaler;
  logic [15:0] score_q;
  logic [15:0] hi_q;
  logic        milestone_q;
  logic        new_record_q;
  logic        inc_q;

  logic [15:0] score_inc;
  logic [6:0]  hundreds;
  logic        ms_hit;
  logic        dead_entry;

  assign gs = gstate_t'(bus.gameState);

  // Four-digit BCD increment; 9999 rolls to 0000.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign score_inc = bcd_inc(score_q);

  // Hundreds count is thousands*10+hundreds,
  // at most 99, so 7 bits suffice.
  assign hundreds =
    7'(score_q[15:12]) * 7'd10 +
    7'(score_q[11:8]);

  // Score just stepped onto a nonzero multiple
  // of the milestone interval.
  assign ms_hit =
    inc_q &&
    (score_q != 16'h0000) &&
    (score_q[7:0] == 8'h00) &&
    ((hundreds % 7'(MILESTONE_HUNDREDS)) == 7'd0);

  assign dead_entry =
    (gs == ST_DEAD) && (prev_state != ST_DEAD);

  // Score, prescaler, high score and event flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state   <= ST_INIT;
      prescaler    <= 6'd0;
      score_q      <= 16'h0000;
      hi_q         <= 16'h0000;
      milestone_q  <= 1'b0;
      new_record_q <= 1'b0;
      inc_q        <= 1'b0;
    end else begin
      prev_state  <= gs;
      milestone_q <= ms_hit;
      inc_q       <= 1'b0;
      unique case (gs)
        ST_INIT, ST_PREPARE: begin
          prescaler    <= 6'd0;
          score_q      <= 16'h0000;
          new_record_q <= 1'b0;
        end
        ST_INGAME: begin
          if (bus.tick) begin
            if (prescaler == PS_LAST) begin
              prescaler <= 6'd0;
              score_q   <= score_inc;
              inc_q     <= 1'b1;
            end else begin
              prescaler <= prescaler + 6'd1;
            end
          end
        end
        ST_DEAD: begin
          // BCD word order matches numeric order.
          if (dead_entry && (score_q > hi_q)) begin
            hi_q         <= score_q;
            new_record_q <= 1'b1;
          end
        end
        default: begin
          prescaler <= prescaler;
        end
      endcase
    end
  end

  assign bus.score      = score_q;
  assign bus.hi_score   = hi_q;
  assign bus.milestone  = milestone_q;
  assign bus.new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (default
// and fast/3-hundred milestone) vs integer model.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if ifa ();
  score_keeper_if ifb ();

  score_keeper dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  score_keeper #(
    .TICKS_PER_POINT    (1),
    .MILESTONE_HUNDREDS (3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int errors = 0;
  int checks = 0;

  // Integer model, one slot per instance.
  int tpp [2] = '{6, 1};
  int mh  [2] = '{1, 3};
  int sc  [2];
  int ps  [2];
  int hi  [2];
  bit rec [2];
  bit incd[2];
  bit ms  [2];
  int prev;

  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sc[i] = 0; ps[i] = 0; hi[i] = 0;
      rec[i] = 0; incd[i] = 0; ms[i] = 0;
    end
    prev = 0;
  endtask

  task automatic model_edge(int gs, bit tk);
    bit ms_new;
    bit inc_new;
    for (int i = 0; i < 2; i++) begin
      ms_new = incd[i] && sc[i] != 0 &&
               sc[i] % 100 == 0 &&
               (sc[i] / 100) % mh[i] == 0;
      inc_new = 0;
      if (gs == 0 || gs == 2) begin
        sc[i] = 0; ps[i] = 0; rec[i] = 0;
      end else if (gs == 1) begin
        if (tk) begin
          if (ps[i] == tpp[i] - 1) begin
            ps[i] = 0;
            sc[i] = (sc[i] + 1) % 10000;
            inc_new = 1;
          end else begin
            ps[i] = ps[i] + 1;
          end
        end
      end else begin
        if (prev != 3 && sc[i] > hi[i]) begin
          hi[i] = sc[i];
          rec[i] = 1;
        end
      end
      ms[i] = ms_new;
      incd[i] = inc_new;
    end
    prev = gs;
  endtask

  task automatic chk(string tag,
                     logic [15:0] obs,
                     logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_a_score"}, ifa.score, to_bcd(sc[0]));
    chk({tag, "_a_hi"}, ifa.hi_score, to_bcd(hi[0]));
    chk({tag, "_a_ms"}, 16'(ifa.milestone),
        16'(ms[0]));
    chk({tag, "_a_rec"}, 16'(ifa.new_record),
        16'(rec[0]));
    chk({tag, "_b_score"}, ifb.score, to_bcd(sc[1]));
    chk({tag, "_b_hi"}, ifb.hi_score, to_bcd(hi[1]));
    chk({tag, "_b_ms"}, 16'(ifb.milestone),
        16'(ms[1]));
    chk({tag, "_b_rec"}, 16'(ifb.new_record),
        16'(rec[1]));
  endtask

  // One clock: drive, edge, model, sample.
  task automatic step(int gs, bit tk);
    ifa.gameState = 2'(gs);
    ifb.gameState = 2'(gs);
    ifa.tick = tk;
    ifb.tick = tk;
    @(posedge clk);
    model_edge(gs, tk);
    #1;
    chk_model("step");
  endtask

  task automatic run_ticks(int n, int maxgap);
    int g;
    for (int k = 0; k < n; k++) begin
      g = (maxgap > 0) ?
          int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) step(1, 1'b0);
      step(1, 1'b1);
    end
  endtask

  // Asynchronous reset asserted between edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_a_score", ifa.score, 16'h0000);
    chk("rst_a_hi", ifa.hi_score, 16'h0000);
    chk("rst_a_ms", 16'(ifa.milestone), 16'h0);
    chk("rst_a_rec", 16'(ifa.new_record), 16'h0);
    chk("rst_b_score", ifb.score, 16'h0000);
    chk("rst_b_hi", ifb.hi_score, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_model("rst_hold");
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int gs;
    ifa.gameState = 2'b00;
    ifb.gameState = 2'b00;
    ifa.tick = 1'b0;
    ifb.tick = 1'b0;
    model_reset();
    #1;
    do_reset();
    step(0, 1'b0);
    step(0, 1'b1);

    // 18 ticks at random spacing.
    run_ticks(18, 3);
    chk("t035_a_score", ifa.score, 16'h0003);
    chk("t035_b_score", ifb.score, 16'h0018);

    // High-score sequence.
    do_reset();
    step(0, 1'b0);
    run_ticks(252, 1);
    chk("t038_run1", ifa.score, 16'h0042);
    step(3, 1'b0);
    chk("t038_hi1", ifa.hi_score, 16'h0042);
    chk("t038_rec1", 16'(ifa.new_record), 16'h1);
    step(3, 1'b1);
    step(3, 1'b0);
    chk("t038_rec_hold", 16'(ifa.new_record), 16'h1);
    step(2, 1'b0);
    chk("t038_prep_sc", ifa.score, 16'h0000);
    chk("t038_prep_rec", 16'(ifa.new_record), 16'h0);
    run_ticks(180, 1);
    chk("t038_run2", ifa.score, 16'h0030);
    step(3, 1'b0);
    chk("t038_hi2", ifa.hi_score, 16'h0042);
    chk("t038_rec2", 16'(ifa.new_record), 16'h0);

    // Death on the same cycle as a tick.
    do_reset();
    run_ticks(47, 0);
    chk("t039_pre", ifa.score, 16'h0007);
    step(3, 1'b1);
    chk("t039_score", ifa.score, 16'h0007);
    chk("t039_hi", ifa.hi_score, 16'h0007);
    chk("t039_b_hi", ifb.hi_score, 16'h0047);

    // Dead straight back to InGame resumes.
    run_ticks(6, 0);
    chk("resume", ifa.score, 16'h0008);

    // Random game-state walk.
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      gs = (r < 6) ? 1 : (r < 8) ? 3 :
           (r == 8) ? 2 : 0;
      step(gs, 1'($urandom_range(0, 1)));
    end

    // Hundred milestone.
    do_reset();
    run_ticks(599, 0);
    chk("t036_pre", ifa.score, 16'h0099);
    step(1, 1'b1);
    chk("t036_score", ifa.score, 16'h0100);
    chk("t036_ms0", 16'(ifa.milestone), 16'h0);
    step(1, 1'b0);
    chk("t036_ms1", 16'(ifa.milestone), 16'h1);
    chk("t036_b_ms", 16'(ifb.milestone), 16'h1);
    step(1, 1'b0);
    chk("t036_ms2", 16'(ifa.milestone), 16'h0);

    // Wrap at 9999 on the fast instance.
    run_ticks(9399, 0);
    chk("t037_pre", ifb.score, 16'h9999);
    step(1, 1'b1);
    chk("t037_wrap", ifb.score, 16'h0000);
    step(1, 1'b0);
    chk("t037_no_ms", 16'(ifb.milestone), 16'h0);

    // Mid-game reset clears everything.
    do_reset();
    run_ticks(3000, 0);
    step(3, 1'b0);
    chk("t040_hi", ifa.hi_score, 16'h0500);
    step(2, 1'b0);
    run_ticks(738, 0);
    chk("t040_sc", ifa.score, 16'h0123);
    do_reset();
    step(3, 1'b0);
    chk("t034_dead", ifa.hi_score, 16'h0000);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
